// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: successive-approximation ADC sequencer for a 12-bit feedback DAC.
// Flow: sample-and-hold for SAMPLE_CYCLES cycles, then 12 one-cycle bit trials
// from MSB to LSB, then a one-cycle DONE that publishes the result on D_out.
// Optional feature macro: SAR_ADC_OVERRUN_EN adds the 'overrun' output, which
// flags a start request that arrives while a conversion is in flight.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | waiting for en & start; dac_code = 0
// ST_SAMPLE  | sample switch closed, sample counter counts down to 0
// ST_CONVERT | one bit trial per cycle, r_bit walks 11 -> 0, dac_en = 1
// ST_DONE    | D_out just loaded, done pulses for this single cycle
module sar_adc_ctrl #(
    parameter int  SAMPLE_CYCLES = 2,
    parameter real Vref          = 3.3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        start,
    input  logic        cmp,
    output logic        sample,
    output logic [11:0] dac_code,
    output logic        dac_en,
    output logic        busy,
    output logic        done,
    output logic [11:0] D_out
`ifdef SAR_ADC_OVERRUN_EN
    ,
    output logic        overrun
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAMPLE  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Sample counter reload: the last SAMPLE cycle is the one where it reads 0.
    localparam logic [3:0] SAMPLE_LAST = 4'(SAMPLE_CYCLES - 1);
    // Full-scale reference only matters to simulation messages; kept for reference.
    localparam int VREF_MV_UNUSED = int'(Vref * 1000.0);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_bit;
    logic [3:0]  w_bit_nxt;
    logic [3:0]  r_scnt;
    logic [3:0]  w_scnt_nxt;
    logic [11:0] r_code;
    logic [11:0] w_code_nxt;
    logic [11:0] r_dout;
    logic [11:0] w_dout_nxt;
    logic [11:0] w_resolved;
    logic        r_armed;
    logic        w_start_acc;

    // A start is only honoured from IDLE, and not on the first edge out of reset.
    assign w_start_acc = (r_state == ST_IDLE) && en && start && r_armed;

    // State, counters, trial code and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_bit   <= 4'd0;
            r_scnt  <= 4'd0;
            r_code  <= 12'd0;
            r_dout  <= 12'd0;
        end else begin
            r_state <= w_state_nxt;
            r_bit   <= w_bit_nxt;
            r_scnt  <= w_scnt_nxt;
            r_code  <= w_code_nxt;
            r_dout  <= w_dout_nxt;
        end
    end

    // Arms start acceptance one edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    // Next-state and datapath update; en low outside IDLE wins over everything.
    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        w_scnt_nxt  = r_scnt;
        w_code_nxt  = r_code;
        w_dout_nxt  = r_dout;
        w_resolved  = r_code;
        w_resolved[r_bit] = cmp;

        case (r_state)
            ST_IDLE: begin
                w_code_nxt = 12'd0;
                w_bit_nxt  = 4'd0;
                w_scnt_nxt = 4'd0;
                if (w_start_acc) begin
                    w_state_nxt = ST_SAMPLE;
                    w_scnt_nxt  = SAMPLE_LAST;
                end
            end
            ST_SAMPLE: begin
                if (r_scnt == 4'd0) begin
                    w_state_nxt = ST_CONVERT;
                    w_bit_nxt   = 4'd11;
                    w_code_nxt  = 12'h800;
                end else begin
                    w_scnt_nxt = r_scnt - 4'd1;
                end
            end
            ST_CONVERT: begin
                if (r_bit == 4'd0) begin
                    w_state_nxt = ST_DONE;
                    w_dout_nxt  = w_resolved;
                    w_code_nxt  = 12'd0;
                end else begin
                    w_code_nxt = w_resolved;
                    w_code_nxt[r_bit - 4'd1] = 1'b1;
                    w_bit_nxt  = r_bit - 4'd1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_code_nxt  = 12'd0;
                w_bit_nxt   = 4'd0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_code_nxt  = 12'd0;
            end
        endcase

        if ((r_state != ST_IDLE) && !en) begin
            w_state_nxt = ST_IDLE;
            w_bit_nxt   = 4'd0;
            w_scnt_nxt  = 4'd0;
            w_code_nxt  = 12'd0;
            w_dout_nxt  = r_dout;
        end
    end

    // Outputs decode straight from the registered state; r_code is 0 outside CONVERT.
    always_comb begin
        sample   = (r_state == ST_SAMPLE);
        dac_en   = (r_state == ST_CONVERT);
        busy     = (r_state != ST_IDLE);
        done     = (r_state == ST_DONE);
        dac_code = r_code;
        D_out    = r_dout;
    end

`ifdef SAR_ADC_OVERRUN_EN
    logic r_overrun;

    // Sticky overrun flag: start seen mid-conversion (DONE excluded), cleared by next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_start_acc) begin
            r_overrun <= 1'b0;
        end else if (start && (r_state != ST_IDLE) && (r_state != ST_DONE)) begin
            r_overrun <= 1'b1;
        end
    end

    assign overrun = r_overrun;
`endif

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Self-checking bench for sar_adc_ctrl: table of conversions, randomized
// conversions against a bit-trial model, plus abort / reset / back-to-back cases.
module tb_sar_adc_ctrl;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst_n, en, start, cmp;
    logic        sample, dac_en, busy, done;
    logic [11:0] dac_code, D_out;
`ifdef SAR_ADC_OVERRUN_EN
    logic        overrun;
`endif

    logic [11:0] vin;
    logic        cmp_auto, cmp_drv;
    logic [11:0] prev_dout;
    int          checks = 0;
    int          errors = 0;

    sar_adc_ctrl #(.SAMPLE_CYCLES(S), .Vref(3.3)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .cmp(cmp),
        .sample(sample), .dac_code(dac_code), .dac_en(dac_en),
        .busy(busy), .done(done), .D_out(D_out)
`ifdef SAR_ADC_OVERRUN_EN
        , .overrun(overrun)
`endif
    );

    always #5 clk = ~clk;

    // Ideal comparator (vin against the DAC level) or a scripted decision bit.
    always_comb cmp = cmp_auto ? (vin >= dac_code) : cmp_drv;

    typedef struct {
        logic [11:0] vin;
        bit          ideal;
        logic [11:0] pat;
        logic [11:0] exp_res;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected DAC level at trial k: resolved upper bits of the result plus the trial bit.
    function automatic logic [11:0] trial_code(input logic [11:0] res, input int k);
        int m;
        m = 4096 - (1 << (12 - k));
        return 12'((int'(res) & m) | (1 << (11 - k)));
    endfunction

    // One full conversion starting at a negedge in IDLE; checks every cycle.
    task automatic conv(input logic [11:0] vin_i, input bit ideal, input logic [11:0] pat,
                        input logic [11:0] exp_res, input bit noise);
        logic [3:0]  es;
        logic [11:0] ed;
        vin      = vin_i;
        cmp_auto = ideal;
        en       = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        for (int j = 0; j <= S + 13; j++) begin
            es = {1'(j <= S + 12), 1'(j < S), 1'(j >= S && j < S + 12), 1'(j == S + 12)};
            ed = (j >= S && j < S + 12) ? trial_code(exp_res, j - S) : 12'd0;
            chk("status", 32'(es), 32'({busy, sample, dac_en, done}));
            chk("dac_code", 32'(dac_code), 32'(ed));
            chk("d_out", 32'(D_out), 32'((j >= S + 12) ? exp_res : prev_dout));
            if (j >= S && j < S + 12) cmp_drv = pat[11 - (j - S)];
            else                      cmp_drv = 1'($urandom);
            if (j == S + 13)  start = 1'b0;
            else if (noise)   start = 1'($urandom);
            else              start = 1'b0;
            if (j < S + 13) @(negedge clk);
        end
        prev_dout = exp_res;
    endtask

    initial begin
        int          n_done;
        int          last_done;
        bit          seen_done;
        logic [11:0] rv, rp;
        bit          ri;

        vecs[0] = '{12'hA5C, 1'b1, 12'h000, 12'hA5C};
        vecs[1] = '{12'hFFF, 1'b1, 12'h000, 12'hFFF};
        vecs[2] = '{12'h000, 1'b1, 12'h000, 12'h000};
        vecs[3] = '{12'h001, 1'b1, 12'h000, 12'h001};
        vecs[4] = '{12'h800, 1'b1, 12'h000, 12'h800};
        vecs[5] = '{12'h7FF, 1'b1, 12'h000, 12'h7FF};
        vecs[6] = '{12'h000, 1'b0, 12'hFFF, 12'hFFF};
        vecs[7] = '{12'h000, 1'b0, 12'h000, 12'h000};
        vecs[8] = '{12'h000, 1'b0, 12'h5A3, 12'h5A3};
        vecs[9] = '{12'h456, 1'b1, 12'h000, 12'h456};

        rst_n = 1'b0; en = 1'b1; start = 1'b0;
        cmp_auto = 1'b1; cmp_drv = 1'b0; vin = 12'd0; prev_dout = 12'd0;
        $display("sar_adc_ctrl bench, SAMPLE_CYCLES=%0d Vref=%f", S, 3.3);

        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({sample, dac_en, busy, done}), 32'd0);
        chk("reset_dac_dout", 32'({dac_code, D_out}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            conv(vecs[i].vin, vecs[i].ideal, vecs[i].pat, vecs[i].exp_res, 1'b0);

        // en dropped at bit 5 of a conversion of 0x123; prior result is 0x456.
        vin = 12'h123; cmp_auto = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (S + 6) @(negedge clk);
        chk("abort_trial_code", 32'(dac_code), 32'h120);
        chk("abort_trial_en", 32'(dac_en), 32'd1);
        en = 1'b0;
        @(negedge clk);
        chk("abort_status", 32'({busy, sample, dac_en, done}), 32'd0);
        chk("abort_dac_code", 32'(dac_code), 32'd0);
        chk("abort_d_out", 32'(D_out), 32'h456);
        en = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);
        chk("abort_d_out_hold", 32'(D_out), 32'h456);

        // Randomized conversions, start noise during busy must be ignored.
        for (int i = 0; i < 16; i++) begin
            ri = 1'($urandom);
            rv = 12'($urandom);
            rp = 12'($urandom);
            conv(rv, ri, rp, ri ? rv : rp, 1'b1);
        end

        // Reset pulsed mid-CONVERT: outputs clear before the next edge.
        vin = 12'h9C3; cmp_auto = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (S + 3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", 32'({sample, dac_en, busy, done}), 32'd0);
        chk("rst_mid_dac_dout", 32'({dac_code, D_out}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk("rst_first_edge_ignored", 32'(busy), 32'd0);
        prev_dout = 12'd0;
        conv(12'h9C3, 1'b1, 12'h000, 12'h9C3, 1'b0);

        // start held high: back-to-back conversions of 0x7FF.
        vin = 12'h7FF; cmp_auto = 1'b1; start = 1'b1;
        n_done = 0; last_done = -1;
        for (int c = 0; c < 3 * (S + 14) + 5; c++) begin
            @(negedge clk);
            if (done) begin
                chk("b2b_d_out", 32'(D_out), 32'h7FF);
                if (last_done >= 0) chk("b2b_period", 32'(c - last_done), 32'(S + 14));
                last_done = c;
                n_done++;
            end
        end
        chk("b2b_count", 32'(n_done >= 3), 32'd1);
        start = 1'b0;
        repeat (S + 16) @(negedge clk);
        chk("b2b_idle", 32'(busy), 32'd0);
        prev_dout = 12'h7FF;

`ifdef SAR_ADC_OVERRUN_EN
        // start during CONVERT flags overrun without disturbing the result.
        vin = 12'h3A5; cmp_auto = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (S + 4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("overrun_set", 32'(overrun), 32'd1);
        repeat (20) @(negedge clk);
        chk("overrun_result", 32'(D_out), 32'h3A5);
        chk("overrun_sticky", 32'(overrun), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("overrun_cleared", 32'(overrun), 32'd0);
        repeat (S + 16) @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sar_adc_ctrl.md
SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

Interface
REQ-001 The block SHALL have parameter SAMPLE_CYCLES, default 2, meaning sample-and-hold cycles before bit trials, legal range 1..15.
REQ-002 The block SHALL have parameter real Vref, default 3.3, meaning full-scale reference, used only by $display in simulation.
REQ-003 clk  input  1  the single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  block enable; low aborts any conversion.
REQ-006 start  input  1  conversion request, sampled on the rising edge while IDLE.
REQ-007 cmp  input  1  comparator result: 1 means Vin >= Vref*dac_code/4096.
REQ-008 sample  output  1  sample-and-hold switch, high during SAMPLE.
REQ-009 dac_code  output  12  trial code to the 12-bit feedback DAC.
REQ-010 dac_en  output  1  DAC enable, high during CONVERT only.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  single-cycle pulse when D_out updates.
REQ-013 D_out  output  12  last completed conversion result.

Function
REQ-014 The FSM SHALL have states IDLE, SAMPLE, CONVERT and DONE, held in a registered state with a 4-bit bit index and a 4-bit sample counter.
REQ-015 IDLE -> SAMPLE on an edge with en=1 and start=1; start is ignored in every other state.
REQ-016 SAMPLE SHALL last exactly SAMPLE_CYCLES cycles with sample=1, then -> CONVERT with bit index 11 and dac_code = 0x800.
REQ-017 In CONVERT at bit i, each rising edge SHALL keep bit i if cmp=1, else clear it; it then sets bit i-1, so lower bits of dac_code are 0 and upper bits hold the resolved values.
REQ-018 After the bit-0 decision the FSM SHALL go to DONE, load D_out with the resolved code and assert done for exactly one cycle, then -> IDLE.
REQ-019 Latency: with start sampled at edge t0, done SHALL be high in the cycle after edge t0+SAMPLE_CYCLES+12, i.e. 12 bit trials of one cycle each.
REQ-020 dac_code SHALL be 0 and dac_en 0 in IDLE, SAMPLE and DONE.
REQ-021 en=0 sampled in any non-IDLE state SHALL abort to IDLE on that edge: no done, D_out unchanged, dac_code 0.
REQ-022 If start=1 is held through DONE, the next conversion SHALL begin on the first IDLE edge, giving back-to-back conversions with one idle cycle between them.
REQ-023 cmp SHALL be ignored outside CONVERT.
REQ-024 Codes SHALL saturate naturally: cmp=1 at every trial gives 0xFFF, and cmp=0 at every trial gives 0x000.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, sample=0, dac_code=0, dac_en=0, busy=0, done=0, D_out=0 and both counters to 0, including mid-conversion.
REQ-026 The first start after rst_n deasserts SHALL be accepted no earlier than the second rising edge after deassertion.

Configuration
REQ-027 With macro SAR_ADC_OVERRUN_EN defined, the block SHALL add an output overrun (1 bit), set when start=1 is sampled while busy=1 (excluding the DONE cycle) and cleared by the next accepted start or by reset.
REQ-028 Without SAR_ADC_OVERRUN_EN, the overrun port and its logic SHALL NOT exist, and start during busy SHALL be silently ignored.

Verification
REQ-029 Ideal comparator model cmp = (vin_code >= dac_code), vin_code=0xA5C, SAMPLE_CYCLES=2, one start pulse -> done pulse at edge t0+14, D_out=0xA5C, dac_code sequence starts 0x800, 0xC00, 0xA00.
REQ-030 vin_code=0xFFF, then vin_code=0x000 -> D_out=0xFFF, then D_out=0x000, each with exactly one done pulse.
REQ-031 en dropped at bit 5 of a conversion with vin_code=0x123 after a prior result 0x456 -> IDLE on the next edge, no done, D_out stays 0x456.
REQ-032 rst_n pulsed low mid-CONVERT -> all outputs are 0 asynchronously before the next edge, and a new start then converts correctly.
REQ-033 start held high continuously with vin_code=0x7FF -> repeated conversions, with done pulses every SAMPLE_CYCLES+14 cycles.
REQ-034 With SAR_ADC_OVERRUN_EN defined, start pulsed in CONVERT -> overrun=1, conversion result unaffected, and overrun=0 after the next accepted start.
